// File: rtl/threshold_order_gen.sv
// threshold_order_gen
// Turns band-state transitions from the price threshold detector into
// BUY/SELL orders on a valid/ready handshake. Keeps a signed net position
// bounded by MAX_POSITION and ignores new events while an order is pending
// and for COOLDOWN_CYCLES cycles after each accepted order.

module threshold_order_gen #(
    parameter int MAX_POSITION    = 3,   // 1..7
    parameter int COOLDOWN_CYCLES = 4    // 0 is legal
) (
    input  logic              clk,
    input  logic              reset,        // synchronous, active low
    input  logic [1:0]        state_in,
    input  logic [7:0]        price,
    output logic              order_valid,
    input  logic              order_ready,
    output logic              order_side,   // 1 = BUY, 0 = SELL
    output logic [7:0]        order_price,
    output logic signed [3:0] position,
    output logic [7:0]        drop_count,
    output logic              err
);

    // Band codes produced by the detector.
    typedef enum logic [1:0] {
        CODE_INV  = 2'b00,
        CODE_BAND = 2'b01,
        CODE_LOW  = 2'b10,
        CODE_HIGH = 2'b11
    } band_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PEND = 2'b01,
        COOL = 2'b10
    } fsm_t;

    // Counter is wide enough to hold COOLDOWN_CYCLES; one bit minimum so a
    // zero cooldown still elaborates.
    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(1);

    localparam logic signed [3:0] POS_MAX = 4'(MAX_POSITION);
    localparam logic signed [3:0] POS_MIN = 4'(-MAX_POSITION);
    localparam logic signed [3:0] POS_ONE = 4'sd1;

    fsm_t             fsm;
    band_t            prev_state;
    logic [CNT_W-1:0] cool_cnt;

    logic code_valid;
    logic buy_evt;
    logic sell_evt;
    logic buy_ok;
    logic sell_ok;
    logic accept;
    logic drop;
    logic handshake;

    // Decode events from the current/previous band codes and classify each
    // one as accepted (starts an order) or dropped.
    always_comb begin
        // NOTE: every signal gets a default before any condition so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        code_valid = 1'b0;
        buy_evt    = 1'b0;
        sell_evt   = 1'b0;
        buy_ok     = 1'b0;
        sell_ok    = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        handshake  = order_valid && order_ready;

        if (state_in != CODE_INV) begin
            code_valid = 1'b1;
            // Entering LOW is a BUY, entering HIGH is a SELL, from either
            // BAND or the opposite extreme. Entering BAND is silent.
            buy_evt  = (state_in == CODE_LOW)  && (prev_state != CODE_LOW);
            sell_evt = (state_in == CODE_HIGH) && (prev_state != CODE_HIGH);
        end

        buy_ok  = (position < POS_MAX);
        sell_ok = (position > POS_MIN);

        // Only IDLE can take a new order; an event seen in PEND (including
        // the handshake edge) or COOL, or one failing the limit, is dropped.
        if (fsm == IDLE) begin
            accept = (buy_evt && buy_ok) || (sell_evt && sell_ok);
        end
        drop = (buy_evt || sell_evt) && !accept;
    end

    // Order FSM: owns the registered order outputs, the net position and the
    // cooldown counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!reset) begin
            fsm         <= IDLE;
            order_valid <= 1'b0;
            order_side  <= 1'b0;
            order_price <= 8'd0;
            position    <= 4'sd0;
            cool_cnt    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        fsm         <= PEND;
                        order_valid <= 1'b1;
                        order_side  <= buy_evt;
                        order_price <= price;
                    end
                end

                PEND: begin
                    // Side and price stay frozen until the order is taken.
                    if (handshake) begin
                        order_valid <= 1'b0;
                        position    <= order_side ? (position + POS_ONE)
                                                  : (position - POS_ONE);
                        cool_cnt    <= COOL_LOAD;
                        fsm         <= (COOLDOWN_CYCLES == 0) ? IDLE : COOL;
                    end
                end

                COOL: begin
                    // Leaving on the count of 1 makes COOL last exactly
                    // COOLDOWN_CYCLES cycles.
                    cool_cnt <= cool_cnt - COOL_LAST;
                    if (cool_cnt == COOL_LAST) begin
                        fsm <= IDLE;
                    end
                end

                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // Band-code history, invalid-code flag and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_state <= CODE_BAND;
            err        <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            err <= !code_valid;
            // An invalid code leaves the history untouched, so returning to
            // the previous code afterwards is not a transition.
            if (code_valid) begin
                prev_state <= band_t'(state_in);
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_threshold_order_gen.sv
// Directed bench for threshold_order_gen (MAX_POSITION=3, COOLDOWN_CYCLES=4).
// Stimulus pushes expected orders into a queue; a monitor pops and compares
// them at each handshake. Register-level expectations are checked inline.

module tb_threshold_order_gen;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        state_in;
    logic [7:0]        price;
    logic              order_valid;
    logic              order_ready;
    logic              order_side;
    logic [7:0]        order_price;
    logic signed [3:0] position;
    logic [7:0]        drop_count;
    logic              err;

    typedef struct {
        logic       side;
        logic [7:0] price;
    } order_t;

    order_t exp_q[$];
    int     n_compared = 0;
    int     n_mismatch = 0;

    threshold_order_gen #(
        .MAX_POSITION   (3),
        .COOLDOWN_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .state_in   (state_in),
        .price      (price),
        .order_valid(order_valid),
        .order_ready(order_ready),
        .order_side (order_side),
        .order_price(order_price),
        .position   (position),
        .drop_count (drop_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks run there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_order(input logic side, input logic [7:0] p);
        order_t o;
        o.side  = side;
        o.price = p;
        exp_q.push_back(o);
    endtask

    // Monitor: inputs are stable from negedge to the next posedge, so a
    // valid&&ready seen here is the handshake at the coming edge.
    always @(negedge clk) begin
        if (reset && order_valid && order_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL unexpected_order: side %0d price %0d with empty queue",
                         order_side, order_price);
            end else begin
                order_t e;
                e = exp_q.pop_front();
                check("sb_side", int'(order_side), int'(e.side));
                check("sb_price", int'(order_price), int'(e.price));
            end
        end
    end

    initial begin
        reset       = 1'b0;
        state_in    = 2'b10;
        price       = 8'd0;
        order_ready = 1'b0;

        // ---------------- reset ----------------
        tick(3);
        check("rst_valid", int'(order_valid), 0);
        check("rst_side", int'(order_side), 0);
        check("rst_price", int'(order_price), 0);
        check("rst_position", int'(position), 0);
        check("rst_drop", int'(drop_count), 0);
        check("rst_err", int'(err), 0);
        reset    = 1'b1;
        state_in = 2'b01;
        tick(2);
        check("post_rst_valid", int'(order_valid), 0);
        check("post_rst_position", int'(position), 0);

        // ---------------- buy path ----------------
        order_ready = 1'b1;
        state_in    = 2'b10;
        price       = 8'd92;
        expect_order(1'b1, 8'd92);
        tick();
        check("buy_valid", int'(order_valid), 1);
        check("buy_side", int'(order_side), 1);
        check("buy_price", int'(order_price), 92);
        tick();
        check("buy_done_valid", int'(order_valid), 0);
        check("buy_position", int'(position), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("buy_hold_no_order", int'(order_valid), 0);
        end
        check("buy_hold_drop", int'(drop_count), 0);

        // ---------------- backpressure and cooldown ----------------
        order_ready = 1'b0;
        state_in    = 2'b11;
        price       = 8'd110;
        expect_order(1'b0, 8'd110);
        tick();
        check("bp_valid_0", int'(order_valid), 1);
        check("bp_side_0", int'(order_side), 0);
        check("bp_price_0", int'(order_price), 110);
        state_in = 2'b01; price = 8'd50;
        tick();
        check("bp_valid_1", int'(order_valid), 1);
        state_in = 2'b10; price = 8'd60;   // BUY event while pending: dropped
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid_hold", int'(order_valid), 1);
            check("bp_side_hold", int'(order_side), 0);
            check("bp_price_hold", int'(order_price), 110);
        end
        check("bp_drop", int'(drop_count), 1);
        order_ready = 1'b1;
        tick();                               // handshake edge H
        check("bp_hs_valid", int'(order_valid), 0);
        check("bp_hs_position", int'(position), 0);
        state_in = 2'b01;
        tick();                               // H+1
        state_in = 2'b11; price = 8'd120;
        tick();                               // H+2: inside cooldown
        check("cool_drop_valid", int'(order_valid), 0);
        check("cool_drop_count", int'(drop_count), 2);
        state_in = 2'b01;
        tick(2);                              // H+3, H+4
        state_in = 2'b10; price = 8'd130;
        expect_order(1'b1, 8'd130);
        tick();                               // H+5: cooldown over
        check("cool_accept_valid", int'(order_valid), 1);
        check("cool_accept_side", int'(order_side), 1);
        check("cool_accept_price", int'(order_price), 130);
        tick();
        check("cool_accept_position", int'(position), 1);
        check("cool_accept_drop", int'(drop_count), 2);

        // ---------------- position limit ----------------
        reset = 1'b0;
        state_in = 2'b01;
        tick(2);
        reset = 1'b1;
        tick();
        check("lim_start_position", int'(position), 0);
        for (int k = 0; k < 4; k++) begin
            state_in = 2'b01;
            tick(6);
            state_in = 2'b10;
            price    = 8'(10 + k);
            if (k < 3) begin
                expect_order(1'b1, 8'(10 + k));
                tick();
                check("lim_valid", int'(order_valid), 1);
                tick();
                check("lim_position", int'(position), k + 1);
            end else begin
                tick();
                check("lim_blocked_valid", int'(order_valid), 0);
                check("lim_blocked_drop", int'(drop_count), 1);
                check("lim_blocked_position", int'(position), 3);
            end
        end

        // ---------------- direct swings ----------------
        tick(6);
        state_in = 2'b11; price = 8'd200;     // LOW -> HIGH: SELL
        expect_order(1'b0, 8'd200);
        tick();
        check("swing_sell_valid", int'(order_valid), 1);
        check("swing_sell_side", int'(order_side), 0);
        check("swing_sell_price", int'(order_price), 200);
        tick();
        check("swing_sell_position", int'(position), 2);
        tick(6);
        state_in = 2'b10; price = 8'd77;      // HIGH -> LOW: BUY
        expect_order(1'b1, 8'd77);
        tick();
        check("swing_buy_valid", int'(order_valid), 1);
        check("swing_buy_side", int'(order_side), 1);
        check("swing_buy_price", int'(order_price), 77);
        tick();
        check("swing_buy_position", int'(position), 3);

        // ---------------- invalid code ----------------
        tick(6);
        state_in = 2'b00;
        tick();
        check("inv_err", int'(err), 1);
        check("inv_valid", int'(order_valid), 0);
        state_in = 2'b10; price = 8'd5;       // back to LOW: not a transition
        tick();
        check("inv_err_clear", int'(err), 0);
        check("inv_no_event", int'(order_valid), 0);
        check("inv_no_drop", int'(drop_count), 1);

        // ---------------- reset while pending ----------------
        order_ready = 1'b0;
        state_in = 2'b11; price = 8'd99;
        tick();
        check("pend_valid", int'(order_valid), 1);
        reset = 1'b0;
        tick();
        check("pend_rst_valid", int'(order_valid), 0);
        check("pend_rst_position", int'(position), 0);
        check("pend_rst_drop", int'(drop_count), 0);
        reset = 1'b1;
        state_in = 2'b01;
        order_ready = 1'b1;
        tick(3);
        check("pend_rst_stays_idle", int'(order_valid), 0);
        check("pend_rst_position_hold", int'(position), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/threshold_order_gen.md
Name: threshold_order_gen

Overview:
- Consumes the 2-bit band-state code and the current 8-bit price from the price threshold detector.
- Converts band-state transitions into buy and sell orders, presented on a valid/ready handshake.
- Tracks net position against a configurable limit and enforces a cooldown after every accepted order.
- Sits directly downstream of the detector and feeds the order-routing logic.

Parameters:
MAX_POSITION, 3, maximum absolute net position in units; legal range 1..7.
COOLDOWN_CYCLES, 4, cycles after an accepted order during which new events are dropped; 0 is legal.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
state_in  input  2  band code from detector: 01 BAND, 11 HIGH, 10 LOW, 00 invalid
price  input  8  unsigned price, sampled alongside state_in
order_valid  output  1  order pending on outputs
order_ready  input  1  downstream accepts order when high with order_valid
order_side  output  1  1 = BUY, 0 = SELL
order_price  output  8  price captured when the event was detected
position  output  4  signed two's-complement net position
drop_count  output  8  saturating count of dropped events
err  output  1  one-cycle pulse on invalid code 00

Behaviour:
- Reset: while reset==0 at a clk edge, all of the following apply:
  - FSM goes to IDLE.
  - prev_state=01.
  - order_valid=0, order_side=0, order_price=0.
  - position=0, drop_count=0, err=0.
  - cooldown counter=0.
  - Reset mid-PEND discards the pending order; position is not changed by that order.
- Event detection, per edge, with valid codes only:
  - BUY event: state_in==10 and prev_state!=10.
  - SELL event: state_in==11 and prev_state!=11.
  - Entering BAND (01) generates no event.
  - A direct LOW->HIGH transition is a SELL event; a direct HIGH->LOW transition is a BUY event.
  - prev_state<=state_in on every valid code, whether or not the event is dropped.
- Invalid code 00: err=1 for exactly the next cycle; prev_state is held; no event is generated.
- FSM states: IDLE, PEND, COOL.
- IDLE:
  - An event that passes the position check moves the FSM to PEND at that edge.
  - order_side and order_price are registered at that same edge, so order_valid rises one cycle after state_in changes (latency 1).
- Position check:
  - BUY is allowed only if position < MAX_POSITION.
  - SELL is allowed only if position > -MAX_POSITION.
  - A failed check drops the event; the FSM stays in IDLE.
- PEND:
  - order_valid=1; order_side and order_price are held stable until the handshake.
  - Handshake occurs at an edge where order_valid && order_ready.
  - At the handshake edge, position += 1 for BUY or -= 1 for SELL.
  - At the handshake edge, the counter is loaded with COOLDOWN_CYCLES and the FSM moves to COOL; if COOLDOWN_CYCLES==0 it moves to IDLE.
  - order_valid=0 in the cycle after the handshake.
  - A handshake combined with a new event at the same edge drops the event.
- COOL:
  - The counter decrements each edge; the FSM returns to IDLE at the edge where the counter is 1.
  - COOL therefore lasts exactly COOLDOWN_CYCLES cycles.
  - Events sampled in any PEND or COOL cycle are dropped.
- drop_count: increments by 1 per dropped event and saturates at 255. Invalid codes are not counted.
- order_ready while order_valid==0 is ignored.
- position never exceeds ±MAX_POSITION.

Test Plan:
- Reset behaviour:
  - Stimulus: hold reset=0 for 3 cycles with state_in=10, then release; keep state_in=01.
  - Required: all outputs 0; no order_valid; position=0.
- Buy path:
  - Stimulus: state_in 01->10 with price=92, order_ready=1.
  - Required: order_valid=1 next cycle, side=1, order_price=92. After the handshake, position=1 and order_valid=0.
  - Then, with state_in=10 held for 5 cycles: no further order.
- Backpressure and cooldown:
  - Stimulus: with order_ready=0, state_in ->11 at price=110.
  - Required: order_valid holds with side=0 and price=110 for 6 cycles. During those cycles state_in 11->01->10 drops the BUY event, so drop_count=1.
  - Then raise order_ready: position decreases by 1. An event 2 cycles later is dropped (COOLDOWN_CYCLES=4); an event 5 cycles later is accepted.
- Position limit:
  - Stimulus: 4 BUY events separated by BAND periods longer than the cooldown.
  - Required: first 3 accepted (position=3); the 4th is dropped and drop_count increments.
- Direct swing:
  - Stimulus: state_in 10->11 with no BAND in between, outside cooldown.
  - Required: SELL order issued with the current price.
- Invalid code and reset mid-order:
  - Stimulus: state_in=00 for 1 cycle.
  - Required: err pulses 1 cycle; prev_state is held, so returning to the prior code produces no event.
  - Stimulus: assert reset while in PEND.
  - Required: order_valid=0 and position=0 after that edge.
